core_slot_feeder: RTL

// - Sits directly upstream of the per-core RISC-V wrapper and feeds its in_desc/in_desc_valid/in_desc_taken port.
// - Learns slot base addresses from the core's slot_wr_* stream and keeps a free-slot list.
// - Binds each incoming packet descriptor to a free slot and emits the 64-bit in_desc.
// - Returns a slot to the free list when the scheduler reports it released.

---
 rtl/slot_feeder_pkg.sv | 41 ++++
 rtl/core_slot_feeder_if.sv | 34 +++
 rtl/slot_free_fifo.sv | 46 ++++
 rtl/core_slot_feeder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/slot_feeder_pkg.sv
// Shared sizes, descriptor field layout and FSM encoding for the per-core slot feeder.
package slot_feeder_pkg;

   localparam int unsigned SLOT_COUNT   = 8;
   localparam int unsigned SLOT_WIDTH   = $clog2(SLOT_COUNT + 1);
   localparam int unsigned SLOT_IDX_W   = $clog2(SLOT_COUNT);
   localparam int unsigned ADDR_WIDTH   = 22;
   localparam int unsigned PORT_WIDTH   = 4;
   localparam int unsigned LEN_WIDTH    = 16;
   localparam int unsigned DESC_WIDTH   = 64;

   // in_desc field placement
   localparam int unsigned LEN_LSB      = 0;
   localparam int unsigned SLOT_LSB     = 16;
   localparam int unsigned SLOT_FIELD_W = 8;
   localparam int unsigned PORT_LSB     = 24;
   localparam int unsigned ADDR_LSB     = 32;
   localparam int unsigned ADDR_FIELD_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } feeder_state_e;

   // Assemble a descriptor; unused bits (reserved nibble, address upper bits) stay zero.
   function automatic logic [DESC_WIDTH-1:0] pack_desc(
      input logic [LEN_WIDTH-1:0]  len,
      input logic [SLOT_WIDTH-1:0] slot,
      input logic [PORT_WIDTH-1:0] port,
      input logic [ADDR_WIDTH-1:0] addr
   );
      logic [DESC_WIDTH-1:0] d;
      d = '0;
      d[LEN_LSB  +: LEN_WIDTH]    = len;
      d[SLOT_LSB +: SLOT_FIELD_W] = SLOT_FIELD_W'(slot);
      d[PORT_LSB +: PORT_WIDTH]   = port;
      d[ADDR_LSB +: ADDR_FIELD_W] = ADDR_FIELD_W'(addr);
      return d;
   endfunction

endpackage

// File: rtl/core_slot_feeder_if.sv
// Handshake bundle between the slot feeder, the slot registration/release source and the core.
interface core_slot_feeder_if;
   import slot_feeder_pkg::*;

   logic [SLOT_WIDTH-1:0] slot_wr_ptr;
   logic [ADDR_WIDTH-1:0] slot_wr_addr;
   logic                  slot_wr_valid;
   logic                  slot_wr_ready;
   logic [LEN_WIDTH-1:0]  pkt_len;
   logic [PORT_WIDTH-1:0] pkt_port;
   logic                  pkt_valid;
   logic                  pkt_ready;
   logic [SLOT_WIDTH-1:0] slot_rel_ptr;
   logic                  slot_rel_valid;
   logic [DESC_WIDTH-1:0] in_desc;
   logic                  in_desc_valid;
   logic                  in_desc_taken;

   modport slave (
      input  slot_wr_ptr, slot_wr_addr, slot_wr_valid,
      input  pkt_len, pkt_port, pkt_valid,
      input  slot_rel_ptr, slot_rel_valid,
      input  in_desc_taken,
      output slot_wr_ready, pkt_ready, in_desc, in_desc_valid
   );

   modport master (
      output slot_wr_ptr, slot_wr_addr, slot_wr_valid,
      output pkt_len, pkt_port, pkt_valid,
      output slot_rel_ptr, slot_rel_valid,
      output in_desc_taken,
      input  slot_wr_ready, pkt_ready, in_desc, in_desc_valid
   );
endinterface

// File: rtl/slot_free_fifo.sv
// Circular free-slot list: one push and one pop port, simultaneous push/pop allowed, registered count.
module slot_free_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             head_c_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
         else if (!push_i && pop_i) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage carries no reset; entries are only read once counted in.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_c_o = mem_q[rd_ptr_q];
   assign count_o  = count_q;

endmodule

// File: rtl/core_slot_feeder.sv
// Binds packet descriptors to free core slots and presents them to the core wrapper.
// Optional statistics counters under SLOT_FEEDER_STATS_EN.
module core_slot_feeder
   import slot_feeder_pkg::*;
(
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   core_slot_feeder_if.slave     bus,
   output logic [SLOT_WIDTH-1:0] free_count,
   output logic                  rel_err
`ifdef SLOT_FEEDER_STATS_EN
   ,
   output logic [31:0]           stat_assigned,
   output logic [31:0]           stat_released
`endif
);

   logic                  run_q;
   logic [SLOT_COUNT-1:0] registered_q;
   logic [SLOT_COUNT-1:0] in_use_q;
   logic [ADDR_WIDTH-1:0] addr_q [SLOT_COUNT];
   feeder_state_e         state_q;
   logic [DESC_WIDTH-1:0] desc_q;
   logic                  desc_valid_q;
   logic                  rel_err_q;

   logic                  wr_fire, wr_in_range, wr_new;
   logic                  rel_in_range, rel_legal, rel_illegal;
   logic [SLOT_IDX_W-1:0] wr_idx, rel_idx, head_idx;
   logic                  push, pop;
   logic [SLOT_WIDTH-1:0] push_data, head;

   // Slot ids are 1-based; index 0 of the tables holds slot 1.
   assign wr_idx       = SLOT_IDX_W'(bus.slot_wr_ptr - SLOT_WIDTH'(1));
   assign rel_idx      = SLOT_IDX_W'(bus.slot_rel_ptr - SLOT_WIDTH'(1));
   assign head_idx     = SLOT_IDX_W'(head - SLOT_WIDTH'(1));

   assign wr_fire      = bus.slot_wr_valid & bus.slot_wr_ready;
   assign wr_in_range  = (bus.slot_wr_ptr != '0) && (bus.slot_wr_ptr <= SLOT_WIDTH'(SLOT_COUNT));
   assign wr_new       = wr_fire & wr_in_range & ~registered_q[wr_idx];
   assign rel_in_range = (bus.slot_rel_ptr != '0) && (bus.slot_rel_ptr <= SLOT_WIDTH'(SLOT_COUNT));
   assign rel_legal    = bus.slot_rel_valid & rel_in_range & in_use_q[rel_idx];
   assign rel_illegal  = bus.slot_rel_valid & ~rel_legal;

   // Registration stalls whenever a release is presented, so one push port suffices.
   assign push      = rel_legal | wr_new;
   assign push_data = rel_legal ? bus.slot_rel_ptr : bus.slot_wr_ptr;
   assign pop       = bus.pkt_valid & bus.pkt_ready;

   assign bus.slot_wr_ready = run_q & ~bus.slot_rel_valid;
   assign bus.pkt_ready     = (state_q == ST_IDLE) && (free_count != '0);
   assign bus.in_desc       = desc_q;
   assign bus.in_desc_valid = desc_valid_q;
   assign rel_err           = rel_err_q;

   slot_free_fifo #(
      .DEPTH (SLOT_COUNT),
      .WIDTH (SLOT_WIDTH)
   ) u_free_fifo (
      .clk_i       (sys_clk),
      .rst_ni      (sys_rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_c_o    (head),
      .count_o     (free_count)
   );

   // Slot ownership bits and the illegal-release pulse.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         run_q        <= 1'b0;
         registered_q <= '0;
         in_use_q     <= '0;
         rel_err_q    <= 1'b0;
      end else begin
         run_q     <= 1'b1;
         rel_err_q <= rel_illegal;
         if (wr_fire && wr_in_range) registered_q[wr_idx] <= 1'b1;
         if (rel_legal)              in_use_q[rel_idx]    <= 1'b0;
         if (pop)                    in_use_q[head_idx]   <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_fire && wr_in_range) addr_q[wr_idx] <= bus.slot_wr_addr;
   end

   // Descriptor hand-off FSM.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         desc_q       <= '0;
         desc_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  desc_q       <= pack_desc(bus.pkt_len, head, bus.pkt_port, addr_q[head_idx]);
                  desc_valid_q <= 1'b1;
                  state_q      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.in_desc_taken) begin
                  desc_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef SLOT_FEEDER_STATS_EN
   logic [31:0] assigned_q, released_q;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         assigned_q <= '0;
         released_q <= '0;
      end else begin
         if (pop)       assigned_q <= assigned_q + 32'd1;
         if (rel_legal) released_q <= released_q + 32'd1;
      end
   end

   assign stat_assigned = assigned_q;
   assign stat_released = released_q;
`endif

endmodule
